// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one main-memory port among NUM_PORTS
// cache-style requesters. Each upstream port holds a one-deep request buffer; the
// downstream side drives a registered address/data/strobe interface to memory.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned PORT_BITS  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*WORD_WIDTH-1:0] din,
    output logic [NUM_PORTS*WORD_WIDTH-1:0] dout,
    input  logic [NUM_PORTS-1:0]            re,
    input  logic [NUM_PORTS-1:0]            we,
    output logic [NUM_PORTS-1:0]            ready,
    output logic [ADDR_WIDTH-1:0]           maddr,
    output logic [WORD_WIDTH-1:0]           mout,
    input  logic [WORD_WIDTH-1:0]           min,
    output logic                            mre,
    output logic                            mwe,
    input  logic                            mready
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e state_q, state_d;

    // Per-port request buffers.
    logic [NUM_PORTS-1:0]  pending_q;
    logic [ADDR_WIDTH-1:0] lat_addr [NUM_PORTS];
    logic [WORD_WIDTH-1:0] lat_din  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  lat_rd;

    // Per-port registered read data.
    logic [WORD_WIDTH-1:0] dout_q [NUM_PORTS];

    // Last granted port; doubles as the port being served while in ISSUE/WAIT.
    logic [PORT_BITS-1:0] last_grant_q;

    logic [PORT_BITS-1:0]  winner;
    logic                  any_pending;
    logic                  grant;
    logic                  done;
    logic                  mre_d;
    logic                  mwe_d;
    logic [ADDR_WIDTH-1:0] maddr_d;
    logic [WORD_WIDTH-1:0] mout_d;

    assign ready = ~pending_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_dout
        assign dout[g*WORD_WIDTH +: WORD_WIDTH] = dout_q[g];
    end

    // Round-robin pick: first pending port after last_grant, wrapping modulo NUM_PORTS.
    always_comb begin
        any_pending = 1'b0;
        winner      = last_grant_q;
        for (int k = 1; k <= int'(NUM_PORTS); k++) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (!any_pending && pending_q[p] &&
                    (p == (int'(last_grant_q) + k) % int'(NUM_PORTS))) begin
                    any_pending = 1'b1;
                    winner      = PORT_BITS'(p);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: grant only when memory is idle, strobe for one cycle, then wait.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_pending && mready) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (mready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: next values of the memory-side registers plus grant/complete pulses.
    always_comb begin
        grant   = 1'b0;
        done    = 1'b0;
        mre_d   = 1'b0;
        mwe_d   = 1'b0;
        maddr_d = maddr;
        mout_d  = mout;
        unique case (state_q)
            StIdle: begin
                if (any_pending && mready) begin
                    grant   = 1'b1;
                    maddr_d = lat_addr[winner];
                    mout_d  = lat_din[winner];
                    mre_d   = lat_rd[winner];
                    mwe_d   = !lat_rd[winner];
                end
            end
            StIssue: begin
                // Strobes drop after their single cycle; address and data hold.
                mre_d = 1'b0;
                mwe_d = 1'b0;
            end
            StWait: begin
                done = mready;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    // Memory-side registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            maddr        <= '0;
            mout         <= '0;
            mre          <= 1'b0;
            mwe          <= 1'b0;
            last_grant_q <= PORT_BITS'(NUM_PORTS - 1);
        end else begin
            maddr <= maddr_d;
            mout  <= mout_d;
            mre   <= mre_d;
            mwe   <= mwe_d;
            if (grant) begin
                last_grant_q <= winner;
            end
        end
    end

    // Pending flags: set on a strobe into an idle buffer, cleared when its op completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (!pending_q[i] && (re[i] || we[i])) begin
                    pending_q[i] <= 1'b1;
                end
            end
            if (done) begin
                pending_q[last_grant_q] <= 1'b0;
            end
        end
    end

    // Request latches: capture address, data and op on acceptance; read wins over write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (!pending_q[i] && (re[i] || we[i])) begin
                lat_addr[i] <= addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                lat_din[i]  <= din[i*WORD_WIDTH +: WORD_WIDTH];
                lat_rd[i]   <= re[i];
            end
        end
    end

    // Read data return: only the granted port's slice is touched, and only for reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                dout_q[i] <= '0;
            end
        end else if (done && lat_rd[last_grant_q]) begin
            dout_q[last_grant_q] <= min;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a memory model that pops an expected-op
// scoreboard whenever the arbiter strobes memory.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] addr = '0;
    logic [127:0] din = '0;
    logic [127:0] dout;
    logic [1:0]   re = '0;
    logic [1:0]   we = '0;
    logic [1:0]   ready;
    logic [63:0]  maddr;
    logic [63:0]  mout;
    logic [63:0]  min = '0;
    logic         mre;
    logic         mwe;
    logic         mready = 1'b1;

    typedef struct {
        logic        rd;
        logic [63:0] a;
        logic [63:0] d;
    } op_t;

    op_t         exp_q[$];
    op_t         cur;
    logic [63:0] mem [logic [63:0]];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_ops = 0;
    int          wait_cycles = 0;
    int          wcnt = 0;

    mem_arbiter #(
        .ADDR_WIDTH(64),
        .WORD_WIDTH(64),
        .NUM_PORTS (2),
        .PORT_BITS (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .re    (re),
        .we    (we),
        .ready (ready),
        .maddr (maddr),
        .mout  (mout),
        .min   (min),
        .mre   (mre),
        .mwe   (mwe),
        .mready(mready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    task automatic push(input logic rd, input logic [63:0] a, input logic [63:0] d);
        op_t e;
        e.rd = rd;
        e.a  = a;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    // One-cycle strobe on port p; called at a negedge, returns at the next negedge.
    task automatic pulse(input int p, input logic rd, input logic wr,
                         input logic [63:0] a, input logic [63:0] d);
        addr[p*64 +: 64] = a;
        din[p*64 +: 64]  = d;
        re[p] = rd;
        we[p] = wr;
        @(negedge clk);
        re[p] = 1'b0;
        we[p] = 1'b0;
    endtask

    // Count negedges from the cycle after the strobe until ready[p] returns.
    task automatic wait_ready(input int p, output int n);
        n = 1;
        while (!ready[p] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 64'(ready[p]), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ready != 2'b11 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(ready), 64'd3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Memory model: checks each strobe against the scoreboard, then stalls wait_cycles.
    always @(negedge clk) begin
        if (rst) begin
            mready = 1'b1;
            wcnt   = 0;
        end else if (mre || mwe) begin
            n_ops++;
            check("strobe_excl", 64'(mre & mwe), 64'd0);
            check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("op_is_read", 64'(mre), 64'(cur.rd));
                check("op_addr", maddr, cur.a);
                if (!cur.rd) check("op_wdata", mout, cur.d);
            end
            if (mwe) mem[maddr] = mout;
            else min = mem_rd(maddr);
            if (wait_cycles > 0) begin
                mready = 1'b0;
                wcnt   = wait_cycles;
            end
        end else if (!mready) begin
            if (wcnt == 0) mready = 1'b1;
            else wcnt--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          n0;
        logic [63:0] e0;
        logic [63:0] e1;

        mem[64'h40] = 64'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", 64'(ready), 64'd3);
        check("rst_mre", 64'(mre), 64'd0);
        check("rst_mwe", 64'(mwe), 64'd0);
        check("rst_maddr", maddr, 64'd0);
        check("rst_mout", mout, 64'd0);
        check("rst_dout0", dout[63:0], 64'd0);
        check("rst_dout1", dout[127:64], 64'd0);

        // Single zero-wait read on port 1, cycle by cycle
        @(negedge clk);
        push(1'b1, 64'h40, 64'd0);
        pulse(1, 1'b1, 1'b0, 64'h40, 64'd0);
        check("t1_c1_mre", 64'(mre), 64'd0);
        check("t1_c1_ready1", 64'(ready[1]), 64'd0);
        @(negedge clk);
        check("t1_c2_mre", 64'(mre), 64'd1);
        check("t1_c2_mwe", 64'(mwe), 64'd0);
        check("t1_c2_maddr", maddr, 64'h40);
        @(negedge clk);
        check("t1_c3_mre", 64'(mre), 64'd0);
        check("t1_c3_ready1", 64'(ready[1]), 64'd0);
        @(negedge clk);
        check("t1_c4_ready1", 64'(ready[1]), 64'd1);
        check("t1_c4_dout1", dout[127:64], 64'hDEAD_BEEF);
        check("t1_c4_dout0", dout[63:0], 64'd0);

        // Write on port 0 with three memory wait cycles
        wait_cycles = 3;
        @(negedge clk);
        push(1'b0, 64'h10, 64'h55);
        pulse(0, 1'b0, 1'b1, 64'h10, 64'h55);
        wait_ready(0, n);
        check("t2_latency", 64'(n), 64'd7);
        check("t2_dout0", dout[63:0], 64'd0);
        wait_cycles = 0;

        // Simultaneous requests after reset: port 0 then port 1, twice
        do_reset();
        e0 = mem_rd(64'h100);
        e1 = mem_rd(64'h200);
        push(1'b1, 64'h100, 64'd0);
        push(1'b1, 64'h200, 64'd0);
        addr = {64'h200, 64'h100};
        re   = 2'b11;
        @(negedge clk);
        re = 2'b00;
        wait_idle();
        check("t3_dout0", dout[63:0], e0);
        check("t3_dout1", dout[127:64], e1);
        push(1'b0, 64'h300, 64'h11);
        push(1'b0, 64'h400, 64'h22);
        addr = {64'h400, 64'h300};
        din  = {64'h22, 64'h11};
        we   = 2'b11;
        @(negedge clk);
        we = 2'b00;
        wait_idle();
        check("t3_wr_dout0", dout[63:0], e0);
        check("t3_wr_dout1", dout[127:64], e1);

        // Port 0 re-strobes whenever ready; port 1's single request is served next
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    int w;
                    w = 0;
                    while (!ready[0] && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                    push(1'b1, 64'h500 + 64'(8 * k), 64'd0);
                    pulse(0, 1'b1, 1'b0, 64'h500 + 64'(8 * k), 64'd0);
                end
            end
            begin
                repeat (2) @(negedge clk);
                push(1'b1, 64'h600, 64'd0);
                pulse(1, 1'b1, 1'b0, 64'h600, 64'd0);
            end
        join
        wait_idle();
        check("t4_dout0", dout[63:0], mem_rd(64'h510));
        check("t4_dout1", dout[127:64], mem_rd(64'h600));

        // re+we together reads; a strobe while busy is dropped
        n0 = n_ops;
        e1 = mem_rd(64'h10);
        push(1'b1, 64'h10, 64'd0);
        pulse(1, 1'b1, 1'b1, 64'h10, 64'h99);
        pulse(1, 1'b0, 1'b1, 64'h20, 64'h77);
        wait_idle();
        repeat (3) @(negedge clk);
        check("t5_op_count", 64'(n_ops - n0), 64'd1);
        check("t5_dout1", dout[127:64], e1);

        // Reset in the middle of a stalled read
        wait_cycles = 5;
        push(1'b1, 64'h300, 64'd0);
        pulse(0, 1'b1, 1'b0, 64'h300, 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("t6_busy", 64'(ready[0]), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_cycles = 0;
        check("t6_mre", 64'(mre), 64'd0);
        check("t6_mwe", 64'(mwe), 64'd0);
        check("t6_ready", 64'(ready), 64'd3);
        check("t6_dout0", dout[63:0], 64'd0);
        check("t6_dout1", dout[127:64], 64'd0);
        @(negedge clk);
        push(1'b1, 64'h40, 64'd0);
        pulse(1, 1'b1, 1'b0, 64'h40, 64'd0);
        wait_ready(1, n);
        check("t6_latency", 64'(n), 64'd4);
        check("t6_dout1_after", dout[127:64], 64'hDEAD_BEEF);
        check("t6_dout0_after", dout[63:0], 64'd0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter that shares one main-memory port among NUM_PORTS requesters, such as several caches or a cache plus a DMA engine. Each upstream port has the same addr/din/dout/re/we/ready protocol the caches present, with a one-deep request buffer. The downstream side drives maddr/mout/min/mre/mwe/mready exactly as a cache's memory side does, so the arbiter sits between the caches and main memory.

Parameters:
ADDR_WIDTH, 64, address width in bits.
WORD_WIDTH, 64, data word width in bits.
NUM_PORTS, 2, number of requesters (1..16).
PORT_BITS, 1, width of the grant index; must satisfy 2^PORT_BITS >= NUM_PORTS.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
din  in  NUM_PORTS*WORD_WIDTH  per-port write data, sliced the same way.
dout  out  NUM_PORTS*WORD_WIDTH  per-port read data (registered).
re  in  NUM_PORTS  per-port read strobe.
we  in  NUM_PORTS  per-port write strobe.
ready  out  NUM_PORTS  per-port idle flag; ready[i] = !pending[i].
maddr  out  ADDR_WIDTH  memory address (registered).
mout  out  WORD_WIDTH  memory write data (registered).
min  in  WORD_WIDTH  memory read data.
mre  out  1  memory read strobe (registered).
mwe  out  1  memory write strobe (registered).
mready  in  1  memory idle / op-complete flag.

Behaviour:
- Reset (rst=1 at posedge):
  - pending=0, state=IDLE, mre=0, mwe=0.
  - maddr=0, mout=0, every dout slice=0.
  - last_grant=NUM_PORTS-1, so port 0 has first priority.
  - A memory op in flight is abandoned; memory is reset alongside the arbiter.
- Upstream capture (every cycle, independent of state):
  - If ready[i] and (re[i] or we[i]): pending[i]<=1; latch addr[i], din[i] and op (read if re[i]).
  - re and we asserted together: treated as a read.
  - Strobes while pending[i]=1 are ignored.
  - Strobes are single-cycle pulses. ready[i] stays 1 during the strobe cycle and drops the next cycle.
- Round-robin: candidate order is last_grant+1, last_grant+2, ... mod NUM_PORTS; the first pending port wins. last_grant updates on grant.
- FSM states:
  - IDLE: if any pending and mready=1, select the winner, load maddr/mout from its latches, set mre (read) or mwe (write) for next cycle, go to ISSUE. Otherwise stay.
  - ISSUE: mre or mwe is high for exactly this one cycle. Clear both strobes; go to WAIT.
  - WAIT: memory must drop mready in this cycle if the op is not complete. When mready=1: for a read, the granted dout slice <=min; pending[grant]<=0; go to IDLE. A zero-wait memory holds mready=1 and completes in the first WAIT cycle.
- Latency (zero-wait memory):
  - Strobe in cycle 0; IDLE grant in cycle 1; mre/mwe in cycle 2; completion in cycle 3; ready[i]=1 and dout valid in cycle 4.
  - Each memory wait cycle adds one cycle.
- Other ports' dout slices are never modified by another port's transaction. Writes leave dout unchanged.
- maddr/mout hold their last value outside ISSUE/WAIT.
- A port whose strobe arrives in the same cycle its previous op completes is not captured (ready=0 that cycle).
- Simultaneous new requests on all ports are each captured. They are served in round-robin order, one memory op at a time. No starvation: worst-case wait is NUM_PORTS-1 transactions.

Test Plan:
- Single read, NUM_PORTS=2, zero-wait memory returning min=64'hDEAD_BEEF for addr 0x40 on port 1 -> mre pulses 1 cycle in cycle 2 with maddr=0x40; dout[1]=0xDEADBEEF and ready[1]=1 at cycle 4; dout[0] stays 0.
- Write on port 0, addr 0x10, din 0x55, memory holds mready low 3 cycles -> mwe pulse with maddr=0x10, mout=0x55; ready[0] returns 1 exactly 3 cycles later than in the zero-wait case.
- Both ports strobe in the same cycle after reset -> port 0 served first, then port 1; a second simultaneous pair is served port 0 then port 1 again (rotation from last_grant=1).
- Port 0 strobes continuously whenever ready while port 1 requests once -> port 1 granted immediately after port 0's current op completes.
- re and we together on port 1 -> only mre is issued, mwe stays 0; a strobe while ready=0 is ignored (exactly one memory op observed).
- rst asserted during WAIT -> next cycle mre=mwe=0, all ready=1, all dout=0; a later request completes normally.
